// File: rtl/bus_ram_pkg.sv
// Shared definitions for the bus_ram dual-port responder.
// Holds the port FSM encoding, write-strobe constants and latency counter width.
package bus_ram_pkg;

    localparam int CNT_W = 4;

    localparam logic [3:0] STRB_NONE = 4'b0000;
    localparam logic [3:0] STRB_WORD = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2,
        ST_GAP  = 2'd3
    } port_state_t;

endpackage

// File: rtl/bus_ram_port.sv
// One valid/ready port sequencer: accepts a granted request, counts wait states,
// pulses ready for one cycle, then inserts a single dead cycle before re-accepting.
module bus_ram_port
    import bus_ram_pkg::*;
#(
    parameter int LATENCY = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic valid,
    input  logic grant,
    output logic req,
    output logic ready
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    port_state_t      state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            ST_IDLE: begin
                if (grant) begin
                    if (LATENCY == 1) begin
                        state_next = ST_RESP;
                    end else begin
                        state_next = ST_WAIT;
                        cnt_next   = CNT_LOAD;
                    end
                end
            end
            // The last wait cycle is the one where the counter shows 1.
            ST_WAIT: begin
                if (cnt_reg <= CNT_W'(1)) begin
                    state_next = ST_RESP;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            ST_RESP: state_next = ST_GAP;
            ST_GAP:  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        req   = (state_reg == ST_IDLE) && valid;
        ready = (state_reg == ST_RESP);
    end

endmodule

// File: rtl/bus_ram.sv
// Dual-port (fetch + data) memory responder for hcore with a shared word array,
// round-robin arbitration, configurable latency and byte-strobe writes.
module bus_ram
    import bus_ram_pkg::*;
#(
    parameter int    DEPTH_WORDS = 4096,
    parameter int    LATENCY     = 1,
    parameter string INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_valid,
    output logic        i_ready,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    input  logic        d_valid,
    output logic        d_ready,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_wstrb,
    output logic [31:0] d_rdata
);

    localparam int AW = $clog2(DEPTH_WORDS);

    logic [31:0]   mem [DEPTH_WORDS];
    logic          i_req, d_req, i_grant, d_grant;
    logic          prio_d_reg, prio_d_next;
    logic [31:0]   i_rdata_reg, d_rdata_reg;
    logic [AW-1:0] i_idx, d_idx;
    logic          i_in_range, d_in_range;
    logic [31:0]   wmask;
    logic          d_write;
    logic          unused_addr_lsbs;

    assign i_idx            = i_addr[AW+1:2];
    assign d_idx            = d_addr[AW+1:2];
    assign i_in_range       = (i_addr[31:AW+2] == '0);
    assign d_in_range       = (d_addr[31:AW+2] == '0);
    assign unused_addr_lsbs = ^{i_addr[1:0], d_addr[1:0]};

    bus_ram_port #(.LATENCY(LATENCY)) u_i_port (
        .clk   (clk),
        .reset (reset),
        .valid (i_valid),
        .grant (i_grant),
        .req   (i_req),
        .ready (i_ready)
    );

    bus_ram_port #(.LATENCY(LATENCY)) u_d_port (
        .clk   (clk),
        .reset (reset),
        .valid (d_valid),
        .grant (d_grant),
        .req   (d_req),
        .ready (d_ready)
    );

    // Priority only rotates when both ports actually contend.
    always_comb begin
        i_grant     = 1'b0;
        d_grant     = 1'b0;
        prio_d_next = prio_d_reg;
        if (i_req && d_req) begin
            if (prio_d_reg) begin
                d_grant     = 1'b1;
                prio_d_next = 1'b0;
            end else begin
                i_grant     = 1'b1;
                prio_d_next = 1'b1;
            end
        end else begin
            i_grant = i_req;
            d_grant = d_req;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prio_d_reg <= 1'b1;
        end else begin
            prio_d_reg <= prio_d_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            i_rdata_reg <= '0;
            d_rdata_reg <= '0;
        end else begin
            if (i_grant) begin
                i_rdata_reg <= i_in_range ? mem[i_idx] : '0;
            end
            if (d_grant) begin
                d_rdata_reg <= d_in_range ? mem[d_idx] : '0;
            end
        end
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_wmask
        assign wmask[8*gi +: 8] = {8{d_wstrb[gi]}};
    end

    // Same-edge read above sees the pre-write word.
    assign d_write = d_grant && d_in_range && (d_wstrb != STRB_NONE);

    always_ff @(posedge clk) begin
        if (d_write) begin
            mem[d_idx] <= (mem[d_idx] & ~wmask) | (d_wdata & wmask);
        end
    end

    assign i_rdata = i_rdata_reg;
    assign d_rdata = d_rdata_reg;

endmodule

// File: tb/tb_bus_ram.sv
// Bench for bus_ram: directed checks on a LATENCY=1 instance, then randomized
// traffic with async resets on a LATENCY=4 instance against a transaction model.
module tb_bus_ram;
    import bus_ram_pkg::*;

    localparam int DEPTH = 4096;
    localparam int LAT   = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    logic        i_valid = 1'b0, d_valid = 1'b0;
    logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0;
    logic [3:0]  d_wstrb = '0;
    logic        i_ready, d_ready;
    logic [31:0] i_rdata, d_rdata;

    logic        f_i_valid = 1'b0, f_d_valid = 1'b0;
    logic [31:0] f_i_addr = '0, f_d_addr = '0, f_d_wdata = '0;
    logic [3:0]  f_d_wstrb = '0;
    logic        f_i_ready, f_d_ready;
    logic [31:0] f_i_rdata, f_d_rdata;

    always #5 clk = ~clk;

    bus_ram #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT), .INIT_FILE("")) u_dut (
        .clk(clk), .reset(reset),
        .i_valid(i_valid), .i_ready(i_ready), .i_addr(i_addr), .i_rdata(i_rdata),
        .d_valid(d_valid), .d_ready(d_ready), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_wstrb(d_wstrb), .d_rdata(d_rdata)
    );

    bus_ram #(.DEPTH_WORDS(DEPTH), .LATENCY(1), .INIT_FILE("")) u_fast (
        .clk(clk), .reset(reset),
        .i_valid(f_i_valid), .i_ready(f_i_ready), .i_addr(f_i_addr), .i_rdata(f_i_rdata),
        .d_valid(f_d_valid), .d_ready(f_d_ready), .d_addr(f_d_addr), .d_wdata(f_d_wdata),
        .d_wstrb(f_d_wstrb), .d_rdata(f_d_rdata)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // ---------------- directed helpers for the LATENCY=1 instance ----------------
    task automatic f_d_op(input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wstrb, output logic [31:0] rdata, output int lat);
        @(negedge clk);
        f_d_valid = 1'b1; f_d_addr = addr; f_d_wdata = wdata; f_d_wstrb = wstrb;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!f_d_ready && lat < 20);
        f_d_valid = 1'b0;
        rdata = f_d_rdata;
        $display("xact fast d addr=%h wstrb=%b wdata=%h rdata=%h lat=%0d", addr, wstrb, wdata, rdata, lat);
        @(negedge clk);
    endtask

    task automatic f_contend(input logic [31:0] wdata, output int i_at, output int d_at,
                             output logic [31:0] i_data);
        @(negedge clk);
        f_i_valid = 1'b1; f_i_addr = 32'h10;
        f_d_valid = 1'b1; f_d_addr = 32'h10; f_d_wdata = wdata; f_d_wstrb = STRB_WORD;
        i_at = 0; d_at = 0; i_data = '0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (f_i_ready && i_at == 0) begin i_at = k; i_data = f_i_rdata; end
            if (f_d_ready && d_at == 0) d_at = k;
            if (i_at != 0) f_i_valid = 1'b0;
            if (d_at != 0) f_d_valid = 1'b0;
        end
        $display("xact fast contend wdata=%h i_at=%0d d_at=%0d i_rdata=%h", wdata, i_at, d_at, i_data);
    endtask

    // ---------------- transaction model for the LATENCY=4 instance ----------------
    logic [31:0] mem_m [int];
    int          edge_n;
    int          i_free, d_free, i_rdy_edge, d_rdy_edge, d_grant_edge;
    bit          prio_d;
    logic [31:0] i_exp, d_exp, i_gaddr, d_gaddr, d_gwdata;
    logic [3:0]  d_gstrb;
    bit          i_known, d_known;
    int          n_resets;

    function automatic void mem_read(input logic [31:0] addr, output logic [31:0] val, output bit known);
        if (addr >= 32'(DEPTH * 4)) begin
            val = '0; known = 1'b1;
        end else if (mem_m.exists(int'(addr >> 2))) begin
            val = mem_m[int'(addr >> 2)]; known = 1'b1;
        end else begin
            val = '0; known = 1'b0;
        end
    endfunction

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
        if ($urandom_range(0, 15) == 0) a = a | 32'h0001_0000;
        else if ($urandom_range(0, 31) == 0) a = a | 32'h8000_0000;
        return a;
    endfunction

    task automatic drive_random();
        int r;
        i_valid = ($urandom_range(0, 9) < 6);
        i_addr  = rand_addr();
        d_valid = ($urandom_range(0, 9) < 6);
        d_addr  = rand_addr();
        d_wdata = $urandom();
        r = $urandom_range(0, 9);
        if (r < 4)      d_wstrb = STRB_NONE;
        else if (r < 6) d_wstrb = STRB_WORD;
        else            d_wstrb = 4'($urandom_range(1, 14));
    endtask

    // Applies the arbitration and access rules for the edge numbered edge_n.
    task automatic model_edge();
        bit ir, dr, gi_i, gi_d;
        logic [31:0] nw;
        ir = i_valid && (edge_n >= i_free);
        dr = d_valid && (edge_n >= d_free);
        gi_i = 1'b0; gi_d = 1'b0;
        if (ir && dr) begin
            if (prio_d) gi_d = 1'b1; else gi_i = 1'b1;
            prio_d = !prio_d;
        end else begin
            gi_i = ir; gi_d = dr;
        end
        if (gi_i) begin
            mem_read(i_addr, i_exp, i_known);
            i_gaddr    = i_addr;
            i_rdy_edge = edge_n + LAT - 1;
            i_free     = edge_n + LAT + 2;
        end
        if (gi_d) begin
            mem_read(d_addr, d_exp, d_known);
            d_gaddr = d_addr; d_gwdata = d_wdata; d_gstrb = d_wstrb;
            if (d_wstrb != STRB_NONE && d_addr < 32'(DEPTH * 4)) begin
                if (d_known || d_wstrb == STRB_WORD) begin
                    nw = d_exp;
                    for (int k = 0; k < 4; k++)
                        if (d_wstrb[k]) nw[8*k +: 8] = d_wdata[8*k +: 8];
                    mem_m[int'(d_addr >> 2)] = nw;
                end
            end
            d_grant_edge = edge_n;
            d_rdy_edge   = edge_n + LAT - 1;
            d_free       = edge_n + LAT + 2;
        end
    endtask

    task automatic check_outputs();
        bit ei, ed;
        ei = (edge_n == i_rdy_edge);
        ed = (edge_n == d_rdy_edge);
        check("i_ready", 32'(i_ready), 32'(ei));
        check("d_ready", 32'(d_ready), 32'(ed));
        if (ei) begin
            if (i_known) check("i_rdata", i_rdata, i_exp);
            $display("xact i rd addr=%h rdata=%h", i_gaddr, i_rdata);
        end
        if (ed) begin
            if (d_known) check("d_rdata", d_rdata, d_exp);
            $display("xact d addr=%h wstrb=%b wdata=%h rdata=%h", d_gaddr, d_gstrb, d_gwdata, d_rdata);
        end
    endtask

    initial begin
        logic [31:0] rd, idat;
        int lat, ia, da;

        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_i_ready", 32'(i_ready), 32'd0);
        check("rst_d_ready", 32'(d_ready), 32'd0);
        check("rst_i_rdata", i_rdata, 32'd0);
        check("rst_d_rdata", d_rdata, 32'd0);
        check("rst_f_i_ready", 32'(f_i_ready), 32'd0);
        check("rst_f_d_ready", 32'(f_d_ready), 32'd0);
        check("rst_f_i_rdata", f_i_rdata, 32'd0);
        check("rst_f_d_rdata", f_d_rdata, 32'd0);

        // Directed sequences on the LATENCY=1 instance
        f_d_op(32'h10, 32'hDEADBEEF, STRB_WORD, rd, lat);
        check("wr_lat", lat, 1);
        f_d_op(32'h10, 32'h0, STRB_NONE, rd, lat);
        check("rd_lat", lat, 1);
        check("rd_word", rd, 32'hDEADBEEF);
        f_d_op(32'h10, 32'h000000AA, 4'b0001, rd, lat);
        check("wr_prev_word", rd, 32'hDEADBEEF);
        f_d_op(32'h13, 32'h0, STRB_NONE, rd, lat);
        check("rd_strb0", rd, 32'hDEADBEAA);
        f_d_op(32'h10, 32'h12340000, 4'b1100, rd, lat);
        f_d_op(32'h10, 32'h0, STRB_NONE, rd, lat);
        check("rd_strb32", rd, 32'h1234BEAA);
        f_d_op(32'h0, 32'h0BADF00D, STRB_WORD, rd, lat);
        f_d_op(32'h0001_0000, 32'h55555555, STRB_WORD, rd, lat);
        check("oor_wr_lat", lat, 1);
        f_d_op(32'h0001_0000, 32'h0, STRB_NONE, rd, lat);
        check("oor_rd_lat", lat, 1);
        check("oor_rd_data", rd, 32'h0);
        f_d_op(32'h0, 32'h0, STRB_NONE, rd, lat);
        check("word0_kept", rd, 32'h0BADF00D);

        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        f_contend(32'hCAFEF00D, ia, da, idat);
        check("cont1_d_at", da, 1);
        check("cont1_i_at", ia, 2);
        check("cont1_i_sees_wr", idat, 32'hCAFEF00D);
        f_contend(32'h11112222, ia, da, idat);
        check("cont2_i_at", ia, 1);
        check("cont2_d_at", da, 2);
        check("cont2_i_sees_old", idat, 32'hCAFEF00D);

        // Randomized traffic on the LATENCY=4 instance
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        edge_n = 0; i_free = 1; d_free = 1; i_rdy_edge = -1; d_rdy_edge = -1;
        d_grant_edge = -100; prio_d = 1'b1; n_resets = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            drive_random();
            edge_n++;
            model_edge();
            @(negedge clk);
            check_outputs();
            if (d_rdy_edge >= edge_n && n_resets < 6 &&
                (edge_n == d_grant_edge + 2 || edge_n == d_rdy_edge) &&
                $urandom_range(0, 3) == 0) begin
                reset = 1'b1; i_valid = 1'b0; d_valid = 1'b0;
                #1;
                check("arst_i_ready", 32'(i_ready), 32'd0);
                check("arst_d_ready", 32'(d_ready), 32'd0);
                check("arst_i_rdata", i_rdata, 32'd0);
                check("arst_d_rdata", d_rdata, 32'd0);
                $display("xact reset at edge %0d", edge_n);
                @(negedge clk);
                edge_n++;
                reset = 1'b0;
                i_free = edge_n + 1; d_free = edge_n + 1;
                i_rdy_edge = -1; d_rdy_edge = -1; prio_d = 1'b1;
                n_resets++;
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
